// File: rtl/ibuf_pkg.sv
// ibuf_pkg: types and constants shared by the input-buffer responder and the
// buffer-interface initiator.
//   rpsel_e : read mode encoding (RR / BR / RP / NE = no request)
//   state_e : write-side block state (FILL / FULL)
//   RD_LAT  : request-to-response latency in cycles
package ibuf_pkg;

   typedef enum logic [1:0] {
      RR = 2'b00,
      BR = 2'b01,
      RP = 2'b10,
      NE = 2'b11
   } rpsel_e;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   localparam int unsigned RD_LAT = 3;

endpackage

// File: rtl/ibuf_bank.sv
// ibuf_bank: one bank of ROWS x COLS x DW pixel storage.
// Ports:
//   clk      clock
//   we_i     write one pixel at (wrow_i, wcol_i)
//   wrow_i   bank row being written
//   wcol_i   pixel column being written
//   wdata_i  pixel value
//   rrow_i   row to read; the whole row is registered every cycle
//   rdata_o  registered row vector, pixel x at [x*DW +: DW]
// Storage has no reset. A read and a write on the same edge return the
// pre-write contents.
module ibuf_bank #(
   parameter  int unsigned ROWS = 4,
   parameter  int unsigned COLS = 8,
   parameter  int unsigned DW   = 8,
   localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [RW-1:0]        wrow_i,
   input  logic [CW-1:0]        wcol_i,
   input  logic [DW-1:0]        wdata_i,
   input  logic [RW-1:0]        rrow_i,
   output logic [COLS*DW-1:0]   rdata_o
);

   logic [COLS*DW-1:0] mem_q [ROWS];
   logic [COLS*DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wrow_i][wcol_i*DW +: DW] <= wdata_i;
      end
      rdata_q <= mem_q[rrow_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ibuf_responder.sv
// ibuf_responder: input-buffer storage answering the initiator's
// rpsel/bank/row/col read protocol with a fixed 3-cycle response.
// Image row y is stored in bank y%POY, bank row y/POY; pixel x in column x.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_data  raster-order pixel write stream
//   blkend       one-cycle pulse when a full block is resident
//   blk_release  one-cycle pulse from the consumer: block consumed
//   rpsel/bank/row/col         read request (rpsel = NE means idle)
//   rd_valid     response valid, 3 cycles after the request cycle
//   rd_data      POY lanes, lane i at [i*COLS*DW +: COLS*DW]
//   addr_err     sticky flag: request with no block resident or bad address
// Optional build macro IBUF_PINGPONG_EN: two block copies, the write half
// fills while the read half is being consumed.
module ibuf_responder
   import ibuf_pkg::*;
#(
   parameter int unsigned POY  = 3,
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 8,
   parameter int unsigned DW   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DW-1:0]           wr_data,
   output logic                    blkend,
   input  logic                    blk_release,
   input  logic [1:0]              rpsel,
   input  logic [1:0]              bank,
   input  logic [1:0]              row,
   input  logic [27:0]             col,
   output logic                    rd_valid,
   output logic [POY*COLS*DW-1:0]  rd_data,
   output logic                    addr_err
);

   localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BW   = (POY  > 1) ? $clog2(POY)  : 1;
   localparam int unsigned LANE = COLS * DW;
`ifdef IBUF_PINGPONG_EN
   localparam int unsigned HALVES = 2;
`else
   localparam int unsigned HALVES = 1;
`endif
   localparam int unsigned NB = HALVES * POY;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   // ---------------- write side ----------------
   state_e           state_q, state_d;
   logic [CW-1:0]    col_cnt_q, col_cnt_d;
   logic [BW-1:0]    bank_cnt_q, bank_cnt_d;
   logic [RW-1:0]    row_cnt_q, row_cnt_d;
   logic             blkend_q, blkend_d;
   logic             accept, col_last, bank_last, row_last, last_pix;
   logic             rd_ok;
   logic [HALVES-1:0] half_wsel;

`ifdef IBUF_PINGPONG_EN
   logic             wr_half_q, wr_half_d;
   logic             busy_q, busy_d;
   logic             busy_eff;
   assign rd_ok     = busy_q;
   assign half_wsel = {wr_half_q, ~wr_half_q};
   assign busy_eff  = busy_q && !blk_release;
`else
   assign rd_ok     = (state_q == FULL);
   assign half_wsel = 1'b1;
`endif

   assign wr_ready  = (state_q == FILL);
   assign accept    = wr_valid && wr_ready;
   assign col_last  = (col_cnt_q  == CW'(COLS - 1));
   assign bank_last = (bank_cnt_q == BW'(POY - 1));
   assign row_last  = (row_cnt_q  == RW'(ROWS - 1));
   assign last_pix  = col_last && bank_last && row_last;

   always_comb begin
      state_d    = state_q;
      col_cnt_d  = col_cnt_q;
      bank_cnt_d = bank_cnt_q;
      row_cnt_d  = row_cnt_q;
      blkend_d   = 1'b0;
`ifdef IBUF_PINGPONG_EN
      wr_half_d  = wr_half_q;
      busy_d     = busy_q;
`endif
      if (accept) begin
         if (col_last) begin
            col_cnt_d = '0;
            if (bank_last) begin
               bank_cnt_d = '0;
               row_cnt_d  = row_last ? '0 : row_cnt_q + 1'b1;
            end else begin
               bank_cnt_d = bank_cnt_q + 1'b1;
            end
         end else begin
            col_cnt_d = col_cnt_q + 1'b1;
         end
      end
      case (state_q)
         FILL: begin
`ifdef IBUF_PINGPONG_EN
            // A release arriving together with the last pixel frees the
            // read half in time for an immediate swap.
            busy_d = busy_eff;
            if (accept && last_pix) begin
               if (!busy_eff) begin
                  wr_half_d = ~wr_half_q;
                  busy_d    = 1'b1;
                  blkend_d  = 1'b1;
               end else begin
                  state_d = FULL;
               end
            end
`else
            if (accept && last_pix) begin
               state_d  = FULL;
               blkend_d = 1'b1;
            end
`endif
         end
         FULL: begin
            if (blk_release) begin
               state_d    = FILL;
               col_cnt_d  = '0;
               bank_cnt_d = '0;
               row_cnt_d  = '0;
`ifdef IBUF_PINGPONG_EN
               wr_half_d  = ~wr_half_q;
               busy_d     = 1'b1;
               blkend_d   = 1'b1;
`endif
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FILL;
         col_cnt_q  <= '0;
         bank_cnt_q <= '0;
         row_cnt_q  <= '0;
         blkend_q   <= 1'b0;
`ifdef IBUF_PINGPONG_EN
         wr_half_q  <= 1'b0;
         busy_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         col_cnt_q  <= col_cnt_d;
         bank_cnt_q <= bank_cnt_d;
         row_cnt_q  <= row_cnt_d;
         blkend_q   <= blkend_d;
`ifdef IBUF_PINGPONG_EN
         wr_half_q  <= wr_half_d;
         busy_q     <= busy_d;
`endif
      end
   end

   assign blkend = blkend_q;

   // ---------------- read pipeline ----------------
   // Stage 1 registers the request and its error status, stage 2 is the
   // bank row read, stage 3 is the lane mux into the output register.
   rpsel_e            req_mode;
   logic              row_oob, bank_oob, col_oob, req_oob;
   logic [RD_LAT-1:0] vld_q;
   rpsel_e            s1_mode_q, s2_mode_q;
   logic [BW-1:0]     s1_bank_q, s2_bank_q;
   logic [RW-1:0]     s1_row_q;
   logic [CW-1:0]     s1_col_q, s2_col_q;
   logic              s1_err_q, s2_err_q;
   logic              s1_half_q, s2_half_q;
   logic [LANE-1:0]   bdat [NB];
   logic [LANE-1:0]   sel_row;
   logic [POY*LANE-1:0] lanes_d, rd_data_q;
   logic              addr_err_q;
   int unsigned       hoff;

   assign req_mode = rpsel_e'(rpsel);

   always_comb begin
      row_oob  = (32'(row)  >= ROWS);
      bank_oob = (32'(bank) >= POY);
      col_oob  = (32'(col)  >= COLS);
      req_oob  = 1'b0;
      case (req_mode)
         RR:      req_oob = row_oob;
         BR:      req_oob = row_oob || bank_oob;
         RP:      req_oob = row_oob || bank_oob || col_oob;
         default: req_oob = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      s1_mode_q <= req_mode;
      s1_bank_q <= BW'(bank);
      s1_row_q  <= RW'(row);
      s1_col_q  <= CW'(col);
      s1_err_q  <= !rd_ok || req_oob;
`ifdef IBUF_PINGPONG_EN
      s1_half_q <= ~wr_half_q;
`else
      s1_half_q <= 1'b0;
`endif
      s2_mode_q <= s1_mode_q;
      s2_bank_q <= s1_bank_q;
      s2_col_q  <= s1_col_q;
      s2_err_q  <= s1_err_q;
      s2_half_q <= s1_half_q;
   end

   for (genvar h = 0; h < HALVES; h++) begin : g_half
      for (genvar b = 0; b < POY; b++) begin : g_bank
         ibuf_bank #(
            .ROWS (ROWS),
            .COLS (COLS),
            .DW   (DW)
         ) u_bank (
            .clk     (clk),
            .we_i    (accept && half_wsel[h] && (bank_cnt_q == BW'(b))),
            .wrow_i  (row_cnt_q),
            .wcol_i  (col_cnt_q),
            .wdata_i (wr_data),
            .rrow_i  (s1_row_q),
            .rdata_o (bdat[h*POY+b])
         );
      end
   end

   always_comb begin
      lanes_d = '0;
      sel_row = '0;
      hoff    = (HALVES > 1 && s2_half_q) ? POY : 0;
      if (!s2_err_q) begin
         case (s2_mode_q)
            RR: begin
               for (int unsigned i = 0; i < POY; i++) begin
                  lanes_d[i*LANE +: LANE] = bdat[IW'(hoff + i)];
               end
            end
            BR: lanes_d[(POY-1)*LANE +: LANE] = bdat[IW'(hoff + 32'(s2_bank_q))];
            RP: begin
               sel_row = bdat[IW'(hoff + 32'(s2_bank_q))];
               lanes_d[(POY-1)*LANE +: DW] = sel_row[s2_col_q*DW +: DW];
            end
            default: lanes_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q      <= '0;
         rd_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         vld_q <= {vld_q[RD_LAT-2:0], (req_mode != NE)};
         if (vld_q[RD_LAT-2]) begin
            rd_data_q <= lanes_d;
            if (s2_err_q) begin
               addr_err_q <= 1'b1;
            end
         end
      end
   end

   assign rd_valid = vld_q[RD_LAT-1];
   assign rd_data  = rd_data_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ibuf_responder.sv
// tb_ibuf_responder: randomized bench for ibuf_responder. Expected responses
// are computed from the image layout (pixel value = block base + y*COLS + x)
// and queued with the cycle they are due.
module tb_ibuf_responder;
   import ibuf_pkg::*;

   localparam int POY  = 3;
   localparam int ROWS = 4;
   localparam int COLS = 8;
   localparam int DW   = 8;
   localparam int LANE = COLS * DW;
   localparam int LW   = POY * LANE;
   localparam int NPIX = POY * ROWS * COLS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          blkend;
   logic          blk_release = 1'b0;
   logic [1:0]    rpsel = 2'b11;
   logic [1:0]    bank = '0;
   logic [1:0]    row = '0;
   logic [27:0]   col = '0;
   logic          rd_valid;
   logic [LW-1:0] rd_data;
   logic          addr_err;

   ibuf_responder #(
      .POY  (POY),
      .ROWS (ROWS),
      .COLS (COLS),
      .DW   (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .blkend      (blkend),
      .blk_release (blk_release),
      .rpsel       (rpsel),
      .bank        (bank),
      .row         (row),
      .col         (col),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int            due;
      logic [LW-1:0] data;
      bit            err;
   } exp_t;
   exp_t q[$];

   bit            res     = 1'b0;
   int            rd_base = 0;
   bit            err_m   = 1'b0;
   logic [LW-1:0] last_d  = '0;
   int            blk_due = -1;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LANE-1:0] row_vec(input int y);
      logic [LANE-1:0] v;
      for (int x = 0; x < COLS; x++) v[x*DW +: DW] = DW'(rd_base + y*COLS + x);
      return v;
   endfunction

   function automatic void model(input int m, input int b, input int r, input int c,
                                 output logic [LW-1:0] d, output bit e);
      logic [LANE-1:0] v;
      d = '0;
      e = 1'b0;
      if (!res) e = 1'b1;
      else if (m == 0) begin
         if (r >= ROWS) e = 1'b1;
         else for (int i = 0; i < POY; i++) d[i*LANE +: LANE] = row_vec(r*POY + i);
      end else if (m == 1) begin
         if (b >= POY || r >= ROWS) e = 1'b1;
         else d[(POY-1)*LANE +: LANE] = row_vec(r*POY + b);
      end else if (m == 2) begin
         if (b >= POY || r >= ROWS || c >= COLS) e = 1'b1;
         else begin
            v = row_vec(r*POY + b);
            d[(POY-1)*LANE +: DW] = v[c*DW +: DW];
         end
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         err_m   = 1'b0;
         last_d  = '0;
         blk_due = -1;
      end else begin
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("rd_valid", LW'(rd_valid), LW'(1));
            check("rd_data", rd_data, e.data);
            last_d = e.data;
            if (e.err) err_m = 1'b1;
         end else begin
            check("rd_idle", LW'(rd_valid), LW'(0));
            check("rd_hold", rd_data, last_d);
         end
         check("addr_err", LW'(addr_err), LW'(err_m));
         check("blkend", LW'(blkend), LW'(cyc == blk_due));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rpsel = 2'b11;
   endtask

   task automatic issue(input int m, input int b, input int r, input int c);
      exp_t e;
      rpsel = 2'(m);
      bank  = 2'(b);
      row   = 2'(r);
      col   = 28'(c);
      if (m != 3) begin
         model(m, b, r, c, e.data, e.err);
         e.due = cyc + 3;
         q.push_back(e);
      end
   endtask

   task automatic write_block(input int base, input bit expect_blk, input int rel_at);
      int p = 0;
      while (p < NPIX) begin
         wr_valid    = ($urandom_range(3) != 0);
         wr_data     = DW'(base + p);
         blk_release = (p == rel_at) && wr_valid;
         check("wr_ready_fill", LW'(wr_ready), LW'(1));
         if (wr_valid && p == NPIX-1 && expect_blk) blk_due = cyc + 1;
         if (wr_valid) p++;
         step();
      end
      wr_valid    = 1'b0;
      blk_release = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int m, b, r, c, s;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_wr_ready", LW'(wr_ready), LW'(1));
      check("rst_blkend", LW'(blkend), LW'(0));
      check("rst_rd_valid", LW'(rd_valid), LW'(0));
      check("rst_rd_data", rd_data, LW'(0));
      check("rst_addr_err", LW'(addr_err), LW'(0));

      // read while no block is resident
      issue(0, 0, 1, 0); step(); idle();
      repeat (4) step();

      write_block(0, 1'b1, -1);
      res = 1'b1; rd_base = 0;
`ifdef IBUF_PINGPONG_EN
      check("wr_ready_after_fill", LW'(wr_ready), LW'(1));
`else
      check("wr_ready_after_fill", LW'(wr_ready), LW'(0));
`endif
      repeat (2) step();

      issue(0, 0, 1, 0); step(); idle();
      repeat (4) step();
      issue(1, 2, 0, 0); step();
      issue(2, 1, 3, 5); step(); idle();
      repeat (4) step();
      issue(2, 1, 3, 9); step();
      issue(2, 1, 3, (1 << 27) | 5); step();
      issue(1, 3, 0, 0); step(); idle();
      repeat (4) step();

      // release coincident with a read of a row that is rewritten next
      issue(0, 0, 0, 0); blk_release = 1'b1; step();
      blk_release = 1'b0; idle(); res = 1'b0;
      write_block(100, 1'b1, 40);
      res = 1'b1; rd_base = 100;
      issue(0, 0, 0, 0); step(); idle();
      repeat (4) step();

      repeat (60) begin
         m = $urandom_range(3);
         b = $urandom_range(3);
         r = $urandom_range(3);
         s = $urandom_range(7);
         if (s == 0) c = (1 << 27) | $urandom_range(7);
         else if (s == 1) c = $urandom_range(15, 8);
         else c = $urandom_range(7);
         issue(m, b, r, c);
         step();
         if ($urandom_range(3) == 0) begin idle(); step(); end
      end
      idle();
      repeat (4) step();

`ifdef IBUF_PINGPONG_EN
      write_block(0, 1'b0, -1);
      check("wr_ready_stall", LW'(wr_ready), LW'(0));
      issue(0, 0, 1, 0); step(); idle();
      repeat (4) step();
      blk_release = 1'b1; blk_due = cyc + 1; step();
      blk_release = 1'b0; rd_base = 0;
      issue(0, 0, 1, 0); step(); idle();
      repeat (4) step();
`endif

      // reset one cycle after a request: the response must never appear
      issue(0, 0, 0, 0); step(); idle();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1; res = 1'b0;
      check("reset_wr_ready", LW'(wr_ready), LW'(1));
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
